// File: rtl/stim_gen_if.sv
// Stimulus bus between stim_gen and the block it drives: a single registered pulse line.
interface stim_gen_if;
  logic stim_out;

  modport master (output stim_out);
  modport slave  (input  stim_out);
endinterface

// File: rtl/stim_gen.sv
// Free-running 1-bit stimulus generator: periodic, LFSR-random or burst pattern chosen at elaboration.
// Optional STIM_JITTER_EN adds 0..3 random extra low cycles to each period in periodic mode.
module stim_gen #(
  parameter int          MODE        = 0,
  parameter int          PERIOD      = 4,
  parameter int          WIDTH       = 1,
  parameter int          START_DELAY = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          THRESH      = 64,
  parameter int          BURST_LEN   = 3,
  parameter int          BURST_GAP   = 8
) (
  input  logic       clk,
  input  logic       rst,
  stim_gen_if.master bus
);

  if (MODE < 0 || MODE > 2) begin : g_bad_mode
    $error("stim_gen: MODE must be 0, 1 or 2");
  end
  if (PERIOD < 2 || PERIOD > 65535) begin : g_bad_period
    $error("stim_gen: PERIOD must be 2..65535");
  end
  if (WIDTH < 1 || WIDTH > PERIOD - 1) begin : g_bad_width
    $error("stim_gen: WIDTH must be 1..PERIOD-1");
  end
  if (START_DELAY < 0 || START_DELAY > 65535) begin : g_bad_delay
    $error("stim_gen: START_DELAY must be 0..65535");
  end
  if (THRESH < 0 || THRESH > 256) begin : g_bad_thresh
    $error("stim_gen: THRESH must be 0..256");
  end
  if (BURST_LEN < 1 || BURST_GAP < 1 || 2 * BURST_LEN + BURST_GAP > 65535) begin : g_bad_burst
    $error("stim_gen: BURST_LEN/BURST_GAP out of range");
  end

`ifdef STIM_JITTER_EN
  // One extra bit so PERIOD plus up to 3 jitter cycles never wraps the phase counter.
  localparam int CW = 17;
`else
  localparam int CW = 16;
`endif

  localparam logic [15:0]   SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0]   DELAY_W   = 16'(START_DELAY);
  localparam logic [CW-1:0] PER_W     = CW'(PERIOD);
  localparam logic [CW-1:0] WID_W     = CW'(WIDTH);
  localparam logic [CW-1:0] BLEN2_W   = CW'(2 * BURST_LEN);
  localparam logic [CW-1:0] BLAST_W   = CW'(2 * BURST_LEN + BURST_GAP - 1);
  localparam logic [8:0]    THR_W     = 9'(THRESH);
  localparam logic [CW-1:0] ONE_W     = CW'(1);

  typedef enum logic {
    ST_DELAY,
    ST_RUN
  } state_t;

  state_t        state_reg = ST_DELAY;
  state_t        state_next;
  logic [15:0]   delay_reg = '0;
  logic [15:0]   delay_next;
  logic [CW-1:0] phase_reg = '0;
  logic [CW-1:0] phase_next;
  logic [15:0]   lfsr_reg  = SEED;
  logic [15:0]   lfsr_next;
  logic          out_reg   = 1'b0;
  logic          out_next;
  logic          run_edge;
  logic [CW-1:0] cur_len;
`ifdef STIM_JITTER_EN
  logic [CW-1:0] len_reg   = CW'(PERIOD);
  logic [CW-1:0] len_next;
`endif

  // Galois form of x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  always_comb begin
    state_next = state_reg;
    delay_next = delay_reg;
    phase_next = phase_reg;
    lfsr_next  = lfsr_reg;
    out_next   = 1'b0;
    run_edge   = 1'b0;
    cur_len    = PER_W;
`ifdef STIM_JITTER_EN
    len_next   = len_reg;
`endif

    // The edge on which the delay count reaches START_DELAY is already pattern cycle 0.
    case (state_reg)
      ST_DELAY: begin
        if (delay_reg == DELAY_W) begin
          state_next = ST_RUN;
          run_edge   = 1'b1;
        end else begin
          delay_next = delay_reg + 16'd1;
        end
      end
      ST_RUN:   run_edge = 1'b1;
      default:  state_next = ST_DELAY;
    endcase

    if (run_edge) begin
      if (MODE == 0) begin
`ifdef STIM_JITTER_EN
        if (phase_reg == '0) begin
          cur_len   = PER_W + CW'(lfsr_reg[1:0]);
          len_next  = cur_len;
          lfsr_next = lfsr_step(lfsr_reg);
        end else begin
          cur_len   = len_reg;
        end
`endif
        out_next   = (phase_reg < WID_W);
        phase_next = (phase_reg == cur_len - ONE_W) ? '0 : phase_reg + ONE_W;
      end else if (MODE == 1) begin
        lfsr_next = lfsr_step(lfsr_reg);
        out_next  = ({1'b0, lfsr_next[7:0]} < THR_W);
      end else begin
        // Even phases inside the burst are high, odd phases and the gap are low.
        out_next   = (phase_reg < BLEN2_W) && !phase_reg[0];
        phase_next = (phase_reg == BLAST_W) ? '0 : phase_reg + ONE_W;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_DELAY;
      delay_reg <= '0;
      phase_reg <= '0;
      lfsr_reg  <= SEED;
      out_reg   <= 1'b0;
`ifdef STIM_JITTER_EN
      len_reg   <= PER_W;
`endif
    end else begin
      state_reg <= state_next;
      delay_reg <= delay_next;
      phase_reg <= phase_next;
      lfsr_reg  <= lfsr_next;
      out_reg   <= out_next;
`ifdef STIM_JITTER_EN
      len_reg   <= len_next;
`endif
    end
  end

  assign bus.stim_out = out_reg;

endmodule

// File: tb/tb_stim_gen.sv
// Bench for stim_gen: six parameterisations run side by side against a behavioural model,
// including a randomly timed asynchronous reset in the middle of a pulse.
module tb_stim_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;
  int n      = 0;   // rising edges seen since reset release
  int hi128  = 0;

  logic [15:0] m_lfsr;
  int          per_start [2];
  int          per_len   [2];
  logic [15:0] per_lfsr  [2];

  stim_gen_if if_per ();
  stim_gen_if if_per5 ();
  stim_gen_if if_r0 ();
  stim_gen_if if_r256 ();
  stim_gen_if if_r128 ();
  stim_gen_if if_bst ();

  stim_gen #(.MODE(0)) u_per (
    .clk(clk), .rst(rst), .bus(if_per)
  );
  stim_gen #(.MODE(0), .PERIOD(5), .WIDTH(3), .START_DELAY(0)) u_per5 (
    .clk(clk), .rst(rst), .bus(if_per5)
  );
  stim_gen #(.MODE(1), .THRESH(0)) u_r0 (
    .clk(clk), .rst(rst), .bus(if_r0)
  );
  stim_gen #(.MODE(1), .THRESH(256)) u_r256 (
    .clk(clk), .rst(rst), .bus(if_r256)
  );
  stim_gen #(.MODE(1), .THRESH(128)) u_r128 (
    .clk(clk), .rst(rst), .bus(if_r128)
  );
  stim_gen #(.MODE(2)) u_bst (
    .clk(clk), .rst(rst), .bus(if_bst)
  );

  // Clock idles low, then starts.
  initial begin
    #20;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic exp_rand(input int th);
    return (n > 2) && (int'(m_lfsr[7:0]) < th);
  endfunction

  // Burst cycle is 2*BURST_LEN+BURST_GAP = 14, so bursts start at edges 3, 17, 31, ...
  function automatic logic exp_burst();
    int k;
    if (n <= 2) return 1'b0;
    k = (n - 3) % 14;
    return (k < 6) && (k % 2 == 0);
  endfunction

  task automatic model_reset();
    n            = 0;
    m_lfsr       = 16'hACE1;
    per_start[0] = 3;
    per_start[1] = 1;
    per_len[0]   = 4;
    per_len[1]   = 5;
    per_lfsr[0]  = 16'hACE1;
    per_lfsr[1]  = 16'hACE1;
  endtask

  // Each period opens at per_start; its first w cycles are high.
  task automatic model_per(input int i, input int p, input int w, output logic e);
    e = 1'b0;
    if (n >= per_start[i]) begin
      if (n == per_start[i]) begin
        per_len[i] = p;
`ifdef STIM_JITTER_EN
        per_len[i]  = p + int'(per_lfsr[i][1:0]);
        per_lfsr[i] = lfsr_step(per_lfsr[i]);
`endif
      end
      e = ((n - per_start[i]) < w);
      if (n - per_start[i] == per_len[i] - 1) per_start[i] = n + 1;
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %b expected %b", tag, n, obs, expv);
    end
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_per"},  if_per.stim_out,  1'b0);
    check({tag, "_per5"}, if_per5.stim_out, 1'b0);
    check({tag, "_r0"},   if_r0.stim_out,   1'b0);
    check({tag, "_r256"}, if_r256.stim_out, 1'b0);
    check({tag, "_r128"}, if_r128.stim_out, 1'b0);
    check({tag, "_bst"},  if_bst.stim_out,  1'b0);
  endtask

  task automatic run_cycles(input int cycles);
    logic e0;
    logic e1;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      n++;
      if (n > 2) m_lfsr = lfsr_step(m_lfsr);
      model_per(0, 4, 1, e0);
      model_per(1, 5, 3, e1);
      @(negedge clk);
      check("periodic",      if_per.stim_out,  e0);
      check("periodic_p5w3", if_per5.stim_out, e1);
      check("random_t0",     if_r0.stim_out,   exp_rand(0));
      check("random_t256",   if_r256.stim_out, exp_rand(256));
      check("random_t128",   if_r128.stim_out, exp_rand(128));
      check("burst",         if_bst.stim_out,  exp_burst());
      if (if_r128.stim_out === 1'b1) hi128++;
    end
  endtask

  initial begin
    int hold;
    int extra;

    model_reset();

    // Power-up: declared initial values, no reset ever asserted yet.
    #5;
    check_all_low("powerup");
    $display("step powerup: outputs low before first edge");

    run_cycles(1000);
    checks++;
    assert (hi128 >= 440 && hi128 <= 560)
    else begin
      errors++;
      $error("FAIL random_t128_density: observed %0d highs expected 440..560", hi128);
    end
    $display("step run1: 1000 cycles, random_t128 high count %0d", hi128);

    // Advance to a random periodic pulse (default periodic high when (n-3)%4==0).
    extra = 4 * int'($urandom_range(0, 5));
    while (((n - 3) % 4) != 0) run_cycles(1);
    run_cycles(extra);
    check("prereset_pulse", if_per.stim_out, 1'b1);

    #2 rst = 1'b0;
    #1;
    check_all_low("async_reset");
    hold = int'($urandom_range(1, 3));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check_all_low("reset_hold");
    end
    #2 rst = 1'b1;
    model_reset();
    $display("step reset: async reset at edge offset %0d, held %0d cycles", extra, hold);

    run_cycles(80);
    $display("step run2: 80 cycles after reset release");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
